// File: rtl/dds_pkg.sv
// Shared DDS definitions: frequency/phase word widths, meter FSM states and
// the edge-count to frequency-word conversion.
package dds_pkg;
  localparam int K_W = 32;
  localparam int P_W = 11;

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} fsm_state_e;

  // Edges counted over a 2^gate_log2 gate, scaled to a K_W-bit DDS frequency word.
  function automatic logic [K_W-1:0] k_from_edges(input logic [K_W-1:0] edges,
                                                  input int gate_log2);
    return edges << (K_W - gate_log2);
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchroniser for an asynchronous input plus a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic q_sync,
  output logic rise
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_sync = sync_q;
  assign rise   = sync_q & ~prev_q;
endmodule

// File: rtl/dds_freq_meter.sv
// Gated edge-counting frequency meter reporting the DDS word K for sig_in.
// Optional high-time measurement enabled by defining DUTY_MEAS_EN.
module dds_freq_meter #(
  parameter int K_W       = 32,
  parameter int GATE_LOG2 = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 cont_en,
  output logic                 busy,
  output logic                 meas_valid,
  output logic [K_W-1:0]       K_meas,
  output logic                 no_sig,
  output logic [GATE_LOG2:0]   duty_cnt
);
  import dds_pkg::*;

  localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;

  fsm_state_e           state_q, state_d;
  logic [GATE_LOG2-1:0] gate_q, gate_d;
  logic [GATE_LOG2-1:0] edge_q, edge_d, edge_nxt;
  logic [K_W-1:0]       k_q, k_d;
  logic                 nosig_q, nosig_d;
  logic                 sig_sync, sig_rise;

  sync_edge_det u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (sig_in),
    .q_sync  (sig_sync),
    .rise    (sig_rise)
  );

  // Result is computed on the way into DONE so it is visible alongside meas_valid;
  // edge_nxt includes an edge landing in the final gate cycle.
  assign edge_nxt = edge_q + GATE_LOG2'(sig_rise);

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    k_d     = k_q;
    nosig_d = nosig_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          gate_d  = '0;
        end
      end
      ARM: begin
        if (sig_rise) begin
          state_d = GATE;
          gate_d  = '0;
          edge_d  = '0;
        end else if (gate_q == GATE_LAST) begin
          state_d = DONE;
          k_d     = '0;
          nosig_d = 1'b1;
        end else begin
          gate_d = gate_q + GATE_LOG2'(1);
        end
      end
      GATE: begin
        edge_d = edge_nxt;
        if (gate_q == GATE_LAST) begin
          state_d = DONE;
          k_d     = K_W'(k_from_edges(dds_pkg::K_W'(edge_nxt), GATE_LOG2));
          nosig_d = 1'b0;
        end else begin
          gate_d = gate_q + GATE_LOG2'(1);
        end
      end
      DONE: begin
        gate_d  = '0;
        state_d = cont_en ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gate_q  <= '0;
      edge_q  <= '0;
      k_q     <= '0;
      nosig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      k_q     <= k_d;
      nosig_q <= nosig_d;
    end
  end

`ifdef DUTY_MEAS_EN
  logic [GATE_LOG2:0] hi_q, hi_d, hi_nxt, duty_q, duty_d;

  assign hi_nxt = hi_q + (GATE_LOG2+1)'(sig_sync);

  always_comb begin
    hi_d   = hi_q;
    duty_d = duty_q;
    case (state_q)
      ARM: begin
        if (sig_rise) hi_d = '0;
        else if (gate_q == GATE_LAST)
          duty_d = sig_sync ? {1'b1, {GATE_LOG2{1'b0}}} : '0;
      end
      GATE: begin
        hi_d = hi_nxt;
        if (gate_q == GATE_LAST) duty_d = hi_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      duty_q <= '0;
    end else begin
      hi_q   <= hi_d;
      duty_q <= duty_d;
    end
  end

  assign duty_cnt = duty_q;
`else
  logic unused_sync;
  assign unused_sync = sig_sync;
  assign duty_cnt    = '0;
`endif

  assign busy       = (state_q != IDLE);
  assign meas_valid = (state_q == DONE);
  assign K_meas     = k_q;
  assign no_sig     = nosig_q;
endmodule
